// File: rtl/clk_switch_pkg.sv
// Shared types and helpers for the glitch-free clock-switch sequencer.
package clk_switch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GATE_OFF = 3'd1,
    SWITCH   = 3'd2,
    GATE_ON  = 3'd3,
    FINISH   = 3'd4
  } sw_state_e;

  localparam int SW_COUNT_W = 16;

  // Width of a counter that must hold values 0..settle.
  function automatic int settle_w(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/clk_switch_settle_timer.sv
// Load/expire down-counter timing one settle phase: loads SETTLE_CYCLES-1 and
// reports expiry on the edge where it reads 0.
module clk_switch_settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= CNT_W'(SETTLE_CYCLES - 1);
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/clk_switch_seq.sv
// Sequencer driving two DCC enables and a DCS select for glitch-free clock switching.
// Optional: define CLK_SWITCH_COUNT_EN to add the sw_count switch counter output.
module clk_switch_seq
  import clk_switch_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = settle_w(SETTLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic done,
  output logic cur_sel,
  output logic dcc_ce_0,
  output logic dcc_ce_1,
  output logic dcs_sel,
  output logic busy
`ifdef CLK_SWITCH_COUNT_EN
  ,
  output logic [SW_COUNT_W-1:0] sw_count
`endif
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("clk_switch_seq: SETTLE_CYCLES must be in 1..255");
    end
  endgenerate

  sw_state_e state;
  logic      sel_q;
  logic      accept, noop, tmr_load, tmr_exp, in_timed;

  assign accept   = req_valid && req_ready;
  assign noop     = (req_sel == cur_sel);
  assign in_timed = (state == GATE_OFF) || (state == SWITCH);
  assign tmr_load = (accept && !noop) || (tmr_exp && in_timed);

  clk_switch_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .expire(tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      cur_sel   <= 1'b0;
      dcc_ce_0  <= 1'b1;
      dcc_ce_1  <= 1'b0;
      dcs_sel   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sel_q     <= req_sel;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (noop) begin
              state <= FINISH;
            end else begin
              state <= GATE_OFF;
              if (req_sel) dcc_ce_0 <= 1'b0;
              else         dcc_ce_1 <= 1'b0;
            end
          end
        end
        GATE_OFF: if (tmr_exp) begin
          dcs_sel <= sel_q;
          state   <= SWITCH;
        end
        SWITCH: if (tmr_exp) begin
          if (sel_q) dcc_ce_1 <= 1'b1;
          else       dcc_ce_0 <= 1'b1;
          state <= GATE_ON;
        end
        GATE_ON: if (tmr_exp) begin
          done  <= 1'b1;
          state <= FINISH;
        end
        FINISH: begin
          // A no-op enters with done low and spends one extra cycle raising it;
          // a real switch enters with done already set and leaves next edge.
          if (done) begin
            done      <= 1'b0;
            cur_sel   <= sel_q;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLK_SWITCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sw_count <= '0;
    else if (state == FINISH && done && sel_q != cur_sel)
      sw_count <= sw_count + 1'b1;
  end
`endif

endmodule
